inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_if.sv | 28 ++
 rtl/inst_queue.sv | 64 ++++++
 tb/tb_inst_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue: upstream push side,
// downstream pop side, branch flush and occupancy.
interface inst_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          valid_i;
  logic          ready_o;
  logic [31:0]   pc_i;
  logic [31:0]   inst_i;
  logic          flush_i;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   pc_o;
  logic [31:0]   inst_o;
  logic [CW-1:0] count_o;

  modport master (
    output valid_i, pc_i, inst_i, flush_i, ready_i,
    input  ready_o, valid_o, pc_o, inst_o, count_o
  );

  modport slave (
    input  valid_i, pc_i, inst_i, flush_i, ready_i,
    output ready_o, valid_o, pc_o, inst_o, count_o
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode. One cycle latency, no bypass,
// flush empties it (pointers to 0) while leaving stored words untouched.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic         m_clock,
  input  logic         p_reset,
  inst_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;

  // Full blocks pushes even when a pop happens in the same cycle (no pass-through).
  assign q.ready_o = (count_reg != FULL);
  assign q.valid_o = (count_reg != '0);
  assign q.count_o = count_reg;
  assign q.pc_o    = pc_mem[rd_ptr_reg];
  assign q.inst_o  = inst_mem[rd_ptr_reg];

  assign push = q.valid_i && q.ready_o && !q.flush_i;
  assign pop  = q.valid_o && q.ready_i && !q.flush_i;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_reg]   <= q.pc_i;
      inst_mem[wr_ptr_reg] <= q.inst_i;
    end
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (q.flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer rollover is the wrap.
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a queue-based reference model checked every cycle,
// plus literal expectations for fill, stream, wrap, flush, full-with-pop and reset.
module tb_inst_queue;
  localparam int DEPTH = 4;

  logic m_clock = 1'b0;
  logic p_reset;

  inst_queue_if #(.DEPTH(DEPTH)) q ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .q       (q.slave)
  );

  always #5 m_clock = ~m_clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];
  logic [31:0] popped[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0F00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO semantics straight from the handshake rules.
  always @(posedge m_clock or posedge p_reset) begin : model
    bit do_pop;
    bit do_push;
    if (p_reset) begin
      m_pc.delete();
      m_inst.delete();
    end else if (q.flush_i) begin
      m_pc.delete();
      m_inst.delete();
      $display("flush");
    end else begin
      do_pop  = (m_pc.size() != 0) && q.ready_i;
      do_push = q.valid_i && (m_pc.size() != DEPTH);
      if (do_pop) begin
        popped.push_back(m_pc[0]);
        $display("pop  pc=%h", m_pc[0]);
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (do_push) begin
        m_pc.push_back(q.pc_i);
        m_inst.push_back(q.inst_i);
        $display("push pc=%h", q.pc_i);
      end
    end
  end

  always @(negedge m_clock) begin
    if (chk_en && !p_reset) begin
      check("count", 32'(q.count_o), m_pc.size());
      check("valid", 32'(q.valid_o), 32'(m_pc.size() != 0));
      check("ready", 32'(q.ready_o), 32'(m_pc.size() != DEPTH));
      if (m_pc.size() != 0) begin
        check("pc_head", q.pc_o, m_pc[0]);
        check("inst_head", q.inst_o, m_inst[0]);
      end
    end
  end

  // Drive one cycle of inputs; returns at the following falling edge.
  task automatic cyc(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    q.valid_i = v;
    q.pc_i    = pc;
    q.inst_i  = inst_of(pc);
    q.ready_i = rdy;
    q.flush_i = fl;
    @(negedge m_clock);
  endtask

  initial begin
    int n;
    int guard;
    p_reset   = 1'b1;
    q.valid_i = 1'b0;
    q.pc_i    = '0;
    q.inst_i  = '0;
    q.ready_i = 1'b0;
    q.flush_i = 1'b0;
    #12;
    check("rst_count", 32'(q.count_o), 0);
    check("rst_valid", 32'(q.valid_o), 0);
    check("rst_ready", 32'(q.ready_o), 1);
    check("rst_pc",    q.pc_o, 0);
    check("rst_inst",  q.inst_o, 0);
    @(negedge m_clock);
    p_reset = 1'b0;
    chk_en  = 1'b1;

    // Fill to full with decode stalled, then a fifth push must be refused.
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0);
    check("fill_count", 32'(q.count_o), 4);
    check("fill_ready", 32'(q.ready_o), 0);
    check("fill_pc",    q.pc_o, 32'h00);
    cyc(1, 32'h10, 0, 0);
    check("fill5_count", 32'(q.count_o), 4);
    check("fill5_pc",    q.pc_o, 32'h00);

    // Full with pop: pop only, then the push lands on the next edge.
    cyc(1, 32'h10, 1, 0);
    check("fullpop_count", 32'(q.count_o), 3);
    check("fullpop_pc",    q.pc_o, 32'h04);
    cyc(1, 32'h10, 0, 0);
    check("refill_count", 32'(q.count_o), 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    check("drain_count", 32'(q.count_o), 0);

    // Streaming: occupancy holds at one and the head tracks the latest push.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'(i * 4), 1, 0);
      check("stream_count", 32'(q.count_o), 1);
      check("stream_pc",    q.pc_o, 32'(i * 4));
    end
    cyc(0, 0, 1, 0);

    // Wrap: ten entries with decode ready every other cycle.
    popped.delete();
    n = 0;
    guard = 0;
    while (popped.size() < 10 && guard < 60) begin
      if (n < 10) begin
        if (m_pc.size() != DEPTH) begin
          cyc(1, 32'(n * 4), guard[0], 0);
          n++;
        end else begin
          cyc(1, 32'(n * 4), guard[0], 0);
        end
      end else begin
        cyc(0, 0, guard[0], 0);
      end
      guard++;
    end
    check("wrap_popped", popped.size(), 10);
    for (int k = 0; k < 10 && k < popped.size(); k++) check("wrap_order", popped[k], 32'(k * 4));

    // Flush while full with a concurrent push: everything dropped.
    for (int i = 0; i < 4; i++) cyc(1, 32'h40 + 32'(i * 4), 0, 0);
    check("preflush_count", 32'(q.count_o), 4);
    cyc(1, 32'h28, 0, 1);
    check("flush_count", 32'(q.count_o), 0);
    check("flush_valid", 32'(q.valid_o), 0);
    cyc(1, 32'h28, 0, 0);
    check("target_count", 32'(q.count_o), 1);
    check("target_pc",    q.pc_o, 32'h28);
    cyc(1, 32'h50, 1, 1);
    cyc(1, 32'h54, 1, 1);
    check("dblflush_count", 32'(q.count_o), 0);
    cyc(1, 32'h60, 0, 0);
    check("postflush_pc", q.pc_o, 32'h60);

    // Mid-stream reset with three held entries clears without a clock edge.
    cyc(1, 32'h64, 0, 0);
    cyc(1, 32'h68, 0, 0);
    check("prereset_count", 32'(q.count_o), 3);
    q.valid_i = 1'b1;
    q.pc_i    = 32'h6C;
    q.inst_i  = inst_of(32'h6C);
    #2 p_reset = 1'b1;
    #1;
    check("arst_count", 32'(q.count_o), 0);
    check("arst_valid", 32'(q.valid_o), 0);
    check("arst_ready", 32'(q.ready_o), 1);
    check("arst_pc",    q.pc_o, 0);
    @(posedge m_clock);
    #1;
    check("arst_hold_count", 32'(q.count_o), 0);
    @(negedge m_clock);
    p_reset = 1'b0;
    cyc(1, 32'h70, 0, 0);
    check("postrst_count", 32'(q.count_o), 1);
    check("postrst_pc",    q.pc_o, 32'h70);
    cyc(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
